branch_predictor: RTL and testbench

- Fetch-stage dynamic branch predictor. Sits directly upstream of the pipeline controller and produces the predicted branch outcome that the controller compares against the resolved outcome.
- Combines a direct-mapped branch history table (BHT) of 2-bit saturating counters with a tagged, direct-mapped branch target buffer (BTB).
- Lookup is combinational on the IF PC. Training is registered from the EX-stage resolution.
- Also keeps saturating performance counters for resolved branches and mispredictions.

---
 rtl/branch_predictor.sv | 134 +++++++++++++
 tb/tb_branch_predictor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: 2-bit counter BHT plus tagged direct-mapped BTB,
// combinational lookup on the IF PC, registered training from EX resolution.
module branch_predictor #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    output logic                  btb_hit,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  update_predicted,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
);

    localparam int unsigned Entries = 1 << INDEX_BITS;
    localparam int unsigned TagBits = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        CtrSnt = 2'b00,
        CtrWnt = 2'b01,
        CtrWt  = 2'b10,
        CtrSt  = 2'b11
    } ctr_e;

    // Flop-based storage so every entry can be cleared by the asynchronous reset.
    ctr_e                  ctr_q    [Entries];
    logic [Entries-1:0]    valid_q;
    logic [TagBits-1:0]    tag_q    [Entries];
    logic [ADDR_WIDTH-1:0] target_q [Entries];

    logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
    logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TagBits-1:0]    lk_tag;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TagBits-1:0]    up_tag;
    logic                  up_tag_hit;
    ctr_e                  up_ctr_d;

    assign lk_idx = lookup_pc[INDEX_BITS+1:2];
    assign lk_tag = lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2];
    assign up_idx = update_pc[INDEX_BITS+1:2];
    assign up_tag = update_pc[ADDR_WIDTH-1:INDEX_BITS+2];

    // Lookup reads only registered state, so a same-cycle update is not visible here.
    always_comb begin
        btb_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = btb_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? target_q[lk_idx] : '0;
    end

    // Next state of the counter at the update index.
    always_comb begin
        up_tag_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_ctr_d   = ctr_q[up_idx];
        if (update_taken) begin
            if (!up_tag_hit) begin
                // Fresh or aliased entry starts weakly taken rather than inheriting history.
                up_ctr_d = CtrWt;
            end else begin
                unique case (ctr_q[up_idx])
                    CtrSnt:  up_ctr_d = CtrWnt;
                    CtrWnt:  up_ctr_d = CtrWt;
                    CtrWt:   up_ctr_d = CtrSt;
                    CtrSt:   up_ctr_d = CtrSt;
                    default: up_ctr_d = CtrWnt;
                endcase
            end
        end else begin
            unique case (ctr_q[up_idx])
                CtrSnt:  up_ctr_d = CtrSnt;
                CtrWnt:  up_ctr_d = CtrSnt;
                CtrWt:   up_ctr_d = CtrWnt;
                CtrSt:   up_ctr_d = CtrWt;
                default: up_ctr_d = CtrWnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < Entries; i++) begin
                ctr_q[i]    <= CtrWnt;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (update_valid) begin
            ctr_q[up_idx] <= up_ctr_d;
            if (update_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= update_target;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_valid) begin
            if (!(&branch_count_q)) begin
                branch_count_d = branch_count_q + 1'b1;
            end
            if ((update_taken != update_predicted) && !(&mispredict_count_q)) begin
                mispredict_count_d = mispredict_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] lookup_pc;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic          btb_hit;
    logic          update_valid;
    logic [AW-1:0] update_pc;
    logic          update_taken;
    logic [AW-1:0] update_target;
    logic          update_predicted;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    branch_predictor #(
        .ADDR_WIDTH(AW),
        .INDEX_BITS(6),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .lookup_pc       (lookup_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .btb_hit         (btb_hit),
        .update_valid    (update_valid),
        .update_pc       (update_pc),
        .update_taken    (update_taken),
        .update_target   (update_target),
        .update_predicted(update_predicted),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          taken;
        logic          hit;
        logic [AW-1:0] tgt;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_bc   = 0;
    int   exp_mc   = 0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Monitor: outputs are combinational, so every queued expectation is due at the next negedge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            chk({mon_e.name, ".pred_taken"}, AW'(pred_taken), AW'(mon_e.taken));
            chk({mon_e.name, ".btb_hit"}, AW'(btb_hit), AW'(mon_e.hit));
            chk({mon_e.name, ".pred_target"}, pred_target, mon_e.tgt);
            chk({mon_e.name, ".branch_count"}, AW'(branch_count), AW'(mon_e.bc));
            chk({mon_e.name, ".mispredict_count"}, AW'(mispredict_count), AW'(mon_e.mc));
        end
    end

    task automatic expect_now(input string name, input logic et, input logic eh,
                              input logic [AW-1:0] etgt);
        q.push_back('{name: name, taken: et, hit: eh, tgt: etgt,
                      bc: CW'(exp_bc), mc: CW'(exp_mc)});
    endtask

    // Drive one cycle; expected outputs reflect state before this cycle's update.
    task automatic step(input string name, input logic [AW-1:0] lpc, input logic uv,
                        input logic [AW-1:0] upc, input logic ut, input logic [AW-1:0] utgt,
                        input logic upred, input logic et, input logic eh,
                        input logic [AW-1:0] etgt);
        lookup_pc        = lpc;
        update_valid     = uv;
        update_pc        = upc;
        update_taken     = ut;
        update_target    = utgt;
        update_predicted = upred;
        expect_now(name, et, eh, etgt);
        @(posedge clk);
        #1;
        if (uv) begin
            if (exp_bc < 15) exp_bc++;
            if ((ut != upred) && (exp_mc < 15)) exp_mc++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    initial begin
        reset            = 1'b0;
        lookup_pc        = 32'h100;
        update_valid     = 1'b0;
        update_pc        = '0;
        update_taken     = 1'b0;
        update_target    = '0;
        update_predicted = 1'b0;
        #1;
        expect_now("in_reset", 1'b0, 1'b0, 32'h0);
        #11;
        reset = 1'b1;
        @(posedge clk);
        #1;

        step("post_reset", 32'h100, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("first_train", 32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 0, 32'h0);   // -> WT
        step("wt_hit", 32'h100, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h200);
        step("wt_nt", 32'h100, 1, 32'h100, 0, 32'h0, 1, 1, 1, 32'h200);         // -> WNT
        step("wnt_nt", 32'h100, 1, 32'h100, 0, 32'h0, 0, 0, 1, 32'h0);          // -> SNT
        step("snt_t", 32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 1, 32'h0);         // -> WNT
        step("wnt_t", 32'h100, 1, 32'h100, 1, 32'h200, 0, 0, 1, 32'h0);         // -> WT
        step("wt_t", 32'h100, 1, 32'h100, 1, 32'h200, 1, 1, 1, 32'h200);        // -> ST
        step("st_t", 32'h100, 1, 32'h100, 1, 32'h200, 1, 1, 1, 32'h200);        // stays ST
        step("st_nt", 32'h100, 1, 32'h100, 0, 32'h0, 1, 1, 1, 32'h200);         // -> WT
        step("st_held", 32'h100, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h200);
        step("to_st", 32'h100, 1, 32'h100, 1, 32'h200, 1, 1, 1, 32'h200);       // -> ST

        // 0x1100 shares index 0 with 0x100 but has tag 0x11.
        step("alias_train", 32'h1100, 1, 32'h1100, 1, 32'h300, 0, 0, 0, 32'h0);
        step("alias_old", 32'h100, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("alias_new", 32'h1100, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h300);
        step("alias_nt", 32'h1100, 1, 32'h1100, 0, 32'h0, 1, 1, 1, 32'h300);     // WT -> WNT
        step("alias_wnt", 32'h1100, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0);

        step("same_cycle", 32'h1100, 1, 32'h1100, 1, 32'h300, 0, 0, 1, 32'h0);   // -> WT
        step("next_cycle", 32'h1103, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h300);
        step("other_idx", 32'h104, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);

        step("uv0_ignored", 32'h1100, 0, 32'h1100, 0, 32'h0, 1, 1, 1, 32'h300);
        step("uv0_after", 32'h1100, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h300);

        // Mispredicted not-taken branches at index 1 push both counters into saturation.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("sat_%0d", i), 32'h1100, 1, 32'h204, 0, 32'h0, 1, 1, 1, 32'h300);
        end
        step("sat_hold", 32'h1100, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h300);
        step("idx1_no_btb", 32'h204, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);

        // Reset during a pending update: the update must be dropped.
        lookup_pc        = 32'h1100;
        update_valid     = 1'b1;
        update_pc        = 32'h1100;
        update_taken     = 1'b0;
        update_target    = 32'h0;
        update_predicted = 1'b1;
        #1;
        reset  = 1'b0;
        exp_bc = 0;
        exp_mc = 0;
        expect_now("mid_reset", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        reset        = 1'b1;
        step("after_reset", 32'h1100, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("after_reset_old", 32'h100, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0);
        step("retrain", 32'h1100, 1, 32'h1100, 1, 32'h300, 1, 0, 0, 32'h0);
        step("retrained", 32'h1100, 0, 32'h0, 0, 32'h0, 0, 1, 1, 32'h300);

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, want 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
